// File: rtl/id_stage_fwd.sv
// Decode stage: register file, EX/MEM/WB operand forwarding, load-use
// interlock, early beq/bne/j resolution and the ID/EX pipeline register.
module id_stage_fwd #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  pc4,
  input  logic [31:0]      inst,
  input  logic             cu_wreg,
  input  logic             cu_m2reg,
  input  logic             cu_wmem,
  input  logic             cu_aluimm,
  input  logic             cu_shift,
  input  logic             cu_regrt,
  input  logic             cu_sext,
  input  logic [2:0]       cu_aluc,
  input  logic             cu_beq,
  input  logic             cu_bne,
  input  logic             cu_jump,
  input  logic             hold,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [AW-1:0]    ex_rn,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             mem_wreg,
  input  logic [AW-1:0]    mem_rn,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_rn,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall,
  output logic             flush_if,
  output logic [1:0]       pcsource,
  output logic [XLEN-1:0]  bpc,
  output logic [XLEN-1:0]  jpc,
  output logic             e_valid,
  output logic             e_wreg,
  output logic             e_m2reg,
  output logic             e_wmem,
  output logic             e_aluimm,
  output logic             e_shift,
  output logic [2:0]       e_aluc,
  output logic [XLEN-1:0]  e_a,
  output logic [XLEN-1:0]  e_b,
  output logic [XLEN-1:0]  e_imm,
  output logic [AW-1:0]    e_rn,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [XLEN-1:0] rf [NREG];
  logic [AW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] fwd_a, fwd_b, imm;
  logic            uses_rt, lu, busy;
  logic            take, jmp, ctl_flow;
  logic            unused_op;

  assign rs = AW'(inst[9:5]);
  assign rt = AW'(inst[4:0]);
  assign rd = AW'(inst[14:10]);
  assign unused_op = ^inst[31:26];

  function automatic logic [XLEN-1:0] pick(
    input logic [AW-1:0] s
  );
    if (s == '0)
      return '0;
    else if (ex_wreg && !ex_m2reg && ex_rn == s)
      return ex_data;
    else if (mem_wreg && mem_rn == s)
      return mem_data;
    else if (wb_we && wb_rn == s)
      return wb_data;
    else
      return rf[s];
  endfunction

  always_comb begin
    fwd_a = pick(rs);
    fwd_b = pick(rt);
  end

  assign uses_rt = !cu_regrt | cu_wmem | cu_beq | cu_bne;
  assign lu = if_valid & ex_wreg & ex_m2reg
            & (ex_rn != '0)
            & ((ex_rn == rs) | (uses_rt & (ex_rn == rt)));
  assign busy = lu | hold;

  assign imm = {{(XLEN-16){cu_sext & inst[25]}}, inst[25:10]};
  assign bpc = pc4 + {imm[XLEN-3:0], 2'b00};
  assign jpc = {pc4[XLEN-1:28], inst[25:0], 2'b00};

  // Redirects are suppressed while the stage is stalled or in reset
  assign take = !clr & if_valid & !busy
              & ((cu_beq & (fwd_a == fwd_b))
              |  (cu_bne & (fwd_a != fwd_b)));
  assign jmp = !clr & if_valid & !busy & cu_jump;
  assign ctl_flow = cu_beq | cu_bne | cu_jump;

  always_comb begin
    pcsource = 2'b00;
    if (jmp)
      pcsource = 2'b11;
    else if (take)
      pcsource = 2'b01;
  end

  assign stall    = !clr & busy;
  assign flush_if = take | jmp;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wb_we && wb_rn != '0) begin
      rf[wb_rn] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (lu && !hold && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr || (!hold && (lu || !if_valid))) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_aluc   <= '0;
      e_a      <= '0;
      e_b      <= '0;
      e_imm    <= '0;
      e_rn     <= '0;
    end else if (!hold) begin
      e_valid  <= 1'b1;
      e_wreg   <= cu_wreg & !ctl_flow;
      e_m2reg  <= cu_m2reg;
      e_wmem   <= cu_wmem & !ctl_flow;
      e_aluimm <= cu_aluimm;
      e_shift  <= cu_shift;
      e_aluc   <= cu_aluc;
      e_a      <= fwd_a;
      e_b      <= fwd_b;
      e_imm    <= imm;
      e_rn     <= cu_regrt ? rt : rd;
    end
  end

endmodule
